// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops and an iterative multiplier.
// Define SEQ_ALU_DIV_EN to build the restoring divider for DIVU/REMU.
module seq_alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // acc: product / remainder, aux: multiplicand / divisor,
    // sh: multiplier / dividend shifting into quotient
    logic [W-1:0]  acc;
    logic [W-1:0]  aux;
    logic [W-1:0]  sh;
    logic [W-1:0]  res;
    logic [SW-1:0] cnt;

    logic [W-1:0]  acc_nx;
    logic [W-1:0]  aux_nx;
    logic [W-1:0]  sh_nx;
    logic [W-1:0]  fin;

    logic is_mul;
    logic is_div;
    logic iter_op;

`ifdef SEQ_ALU_DIV_EN
    logic       div_q;
    logic       rem_q;
    logic [W:0] rem_sh;
    logic [W:0] diff;
`endif

    function automatic logic [W-1:0] alu_fn(
        input logic [OPCODE_LENGTH-1:0] op,
        input logic [W-1:0]             a,
        input logic [W-1:0]             b
    );
        logic [SW-1:0] s;
        s = b[SW-1:0];
        alu_fn = '0;
        case (op)
            4'b0000: alu_fn = a & b;
            4'b0001: alu_fn = a | b;
            4'b0010: alu_fn = a + b;
            4'b0011: alu_fn = a - b;
            4'b0100: alu_fn = a ^ b;
            4'b0101: alu_fn = a << s;
            4'b0110: alu_fn = a >> s;
            4'b0111: alu_fn = $unsigned($signed(a) >>> s);
            4'b1000: alu_fn = {{(W-1){1'b0}}, a == b};
            4'b1001: alu_fn = {{(W-1){1'b0}}, a != b};
            4'b1010: alu_fn = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1011: alu_fn = {{(W-1){1'b0}}, a < b};
            4'b1100: alu_fn = '0;
`ifdef SEQ_ALU_DIV_EN
            // only reached here on a zero divisor
            4'b1101: alu_fn = '1;
            4'b1110: alu_fn = a;
`else
            4'b1101: alu_fn = '0;
            4'b1110: alu_fn = '0;
`endif
            4'b1111: alu_fn = {{(W-1){1'b0}}, $signed(a) >= $signed(b)};
            default: alu_fn = '0;
        endcase
    endfunction

    assign is_mul = (Operation == 4'b1100);
`ifdef SEQ_ALU_DIV_EN
    assign is_div = ((Operation == 4'b1101) || (Operation == 4'b1110))
                 && (SrcB != '0);
`else
    assign is_div = 1'b0;
`endif
    assign iter_op = is_mul | is_div;

    // one shift-add or restore step per BUSY cycle
    always_comb begin
        acc_nx = acc + (sh[0] ? aux : '0);
        aux_nx = aux << 1;
        sh_nx  = sh >> 1;
        fin    = acc_nx;
`ifdef SEQ_ALU_DIV_EN
        rem_sh = {acc, sh[W-1]};
        diff   = rem_sh - {1'b0, aux};
        if (div_q) begin
            aux_nx = aux;
            acc_nx = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
            sh_nx  = {sh[W-2:0], ~diff[W]};
            fin    = rem_q ? acc_nx : sh_nx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = iter_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            aux <= '0;
            sh  <= '0;
            cnt <= '0;
            res <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= 1'b0;
            rem_q <= 1'b0;
`endif
        end else if (flush) begin
            acc <= '0;
            aux <= '0;
            sh  <= '0;
            cnt <= '0;
            res <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= 1'b0;
            rem_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        if (is_mul) begin
                            acc <= '0;
                            aux <= SrcA;
                            sh  <= SrcB;
                        end else if (is_div) begin
                            acc <= '0;
                            aux <= SrcB;
                            sh  <= SrcA;
                        end else begin
                            res <= alu_fn(Operation, SrcA, SrcB);
                        end
`ifdef SEQ_ALU_DIV_EN
                        div_q <= is_div;
                        rem_q <= Operation[1];
`endif
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        res <= fin;
                        acc <= '0;
                        aux <= '0;
                        sh  <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= acc_nx;
                        aux <= aux_nx;
                        sh  <= sh_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        res <= '0;
                    end
                end
                default: res <= '0;
            endcase
        end
    end

    assign ALUResult = res;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against a
// behavioural model of the opcode table and handshake latency.
module tb_seq_alu;

    localparam int W = 32;
    localparam int LIMIT = 3 * W;

`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [3:0]   operation;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;

    int vectors;
    int miscompares;

    seq_alu #(
        .DATA_WIDTH(W),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .SrcA(srca),
        .SrcB(srcb),
        .Operation(operation),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUResult(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(
        input logic [3:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        int           s;
        logic [W-1:0] ones;
        logic [W-1:0] r;
        s    = int'(b % W);
        ones = '1;
        r    = '0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << s;
            4'd6:  r = a >> s;
            4'd7: begin
                r = a >> s;
                if (a[W-1]) r = r | ~(ones >> s);
            end
            4'd8:  r = (a == b) ? 1 : 0;
            4'd9:  r = (a != b) ? 1 : 0;
            4'd10: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd11: r = (a < b) ? 1 : 0;
            4'd12: r = a * b;
            4'd13: r = !DIV_EN ? '0 : (b == 0) ? ones : a / b;
            4'd14: r = !DIV_EN ? '0 : (b == 0) ? a : a % b;
            default: r = ($signed(a) >= $signed(b)) ? 1 : 0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd12) return W + 1;
        if (DIV_EN && (op == 4'd13 || op == 4'd14) && b != 0) return W + 1;
        return 1;
    endfunction

    // drives one request and waits for its result; no checking here
    task automatic issue(
        input  logic [3:0]   op,
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] res,
        output int           lat,
        output bit           rdy_bad,
        output bit           idle_ok
    );
        @(negedge clk);
        idle_ok   = (in_ready === 1'b1);
        srca      = a;
        srcb      = b;
        operation = op;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        rdy_bad  = 1'b0;
        while (out_valid !== 1'b1 && lat < LIMIT) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready !== 1'b0) rdy_bad = 1'b1;
        res = alu_result;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        srca      = '0;
        srcb      = '0;
        operation = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || alu_result !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b res=%h want 0/0",
                     out_valid, alu_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got ready=%b valid=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] r;
        int           lat;
        bit           bad;
        bit           idle;
        logic [3:0]   ops[4];
        logic [W-1:0] as[4];
        logic [W-1:0] bs[4];
        logic [W-1:0] es[4];
        ops = '{4'd2, 4'd10, 4'd11, 4'd7};
        as  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        bs  = '{32'h1, 32'h1, 32'h1, 32'h24};
        es  = '{32'h80000000, 32'h1, 32'h0, 32'hF8000000};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], r, lat, bad, idle);
            vectors++;
            if (r !== es[i] || lat != 1 || bad || !idle) begin
                miscompares++;
                $display("FAIL directed%0d: got %h lat %0d want %h lat 1",
                         i, r, lat, es[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] r;
        int           lat;
        bit           bad;
        bit           idle;
        issue(4'd12, 32'h0000FFFF, 32'h00010001, r, lat, bad, idle);
        vectors++;
        if (r !== 32'hFFFFFFFF || lat != W + 1 || bad) begin
            miscompares++;
            $display("FAIL mul: got %h lat %0d rdybad %b want ffffffff lat %0d",
                     r, lat, bad, W + 1);
        end
    endtask

    task automatic test_div();
        logic [W-1:0] r;
        int           lat;
        bit           bad;
        bit           idle;
        logic [3:0]   ops[3];
        logic [W-1:0] bs[3];
        logic [W-1:0] es[3];
        int           ls[3];
        ops = '{4'd13, 4'd14, 4'd13};
        bs  = '{32'd7, 32'd7, 32'd0};
        if (DIV_EN) begin
            es = '{32'd14, 32'd2, 32'hFFFFFFFF};
            ls = '{W + 1, W + 1, 1};
        end else begin
            es = '{32'd0, 32'd0, 32'd0};
            ls = '{1, 1, 1};
        end
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], (i == 2) ? 32'd5 : 32'd100, bs[i], r, lat, bad, idle);
            vectors++;
            if (r !== es[i] || lat != ls[i] || bad) begin
                miscompares++;
                $display("FAIL div%0d: got %h lat %0d want %h lat %0d",
                         i, r, lat, es[i], ls[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] r;
        logic [W-1:0] e;
        int           lat;
        bit           bad;
        bit           idle;
        @(negedge clk);
        out_ready = 1'b0;
        e = 32'hDEADBEEF ^ 32'h12345678;
        issue(4'd4, 32'hDEADBEEF, 32'h12345678, r, lat, bad, idle);
        vectors++;
        if (r !== e || lat != 1) begin
            miscompares++;
            $display("FAIL stall_first: got %h lat %0d want %h lat 1", r, lat, e);
        end
        srca      = 32'h1;
        srcb      = 32'h2;
        operation = 4'd2;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || alu_result !== e || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b r=%h rdy=%b want 1/%h/0",
                         i, out_valid, alu_result, in_ready, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || alu_result !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got v=%b r=%h rdy=%b want 0/0/1",
                     out_valid, alu_result, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] r;
        int           lat;
        bit           bad;
        bit           idle;
        int           seen;
        @(negedge clk);
        srca      = 32'h1234;
        srcb      = 32'h5678;
        operation = 4'd12;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== '0) begin
            miscompares++;
            $display("FAIL flush_busy: got rdy=%b v=%b r=%h want 1/0/0",
                     in_ready, out_valid, alu_result);
        end
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_quiet: got %0d valid cycles want 0", seen);
        end
        in_valid  = 1'b1;
        operation = 4'd0;
        flush     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_priority: got rdy=%b v=%b want 1/0",
                     in_ready, out_valid);
        end
        issue(4'd3, 32'd10, 32'd11, r, lat, bad, idle);
        vectors++;
        if (r !== 32'hFFFFFFFF || lat != 1 || !idle) begin
            miscompares++;
            $display("FAIL flush_after: got %h lat %0d want ffffffff lat 1", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        logic [W-1:0] e;
        int           lat;
        bit           bad;
        bit           idle;
        @(negedge clk);
        srca      = 32'd1000;
        srcb      = 32'd3;
        operation = DIV_EN ? 4'd13 : 4'd12;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== '0) begin
            miscompares++;
            $display("FAIL reset_busy: got rdy=%b v=%b r=%h want 1/0/0",
                     in_ready, out_valid, alu_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = model(4'd14, 32'd1000, 32'd3);
        issue(4'd14, 32'd1000, 32'd3, r, lat, bad, idle);
        vectors++;
        if (r !== e || lat != exp_lat(4'd14, 32'd3) || !idle) begin
            miscompares++;
            $display("FAIL reset_next: got %h lat %0d want %h lat %0d",
                     r, lat, e, exp_lat(4'd14, 32'd3));
        end
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'd1, 32'hF0, 32'h0F, r, lat, bad, idle);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || alu_result !== '0) begin
            miscompares++;
            $display("FAIL reset_done: got v=%b r=%h want 0/0",
                     out_valid, alu_result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] r;
        logic [W-1:0] e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        int           lat;
        int           el;
        bit           bad;
        bit           idle;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(0, 40);
                2: b = '0;
                default: b = a;
            endcase
            e  = model(op, a, b);
            el = exp_lat(op, b);
            issue(op, a, b, r, lat, bad, idle);
            vectors++;
            if (r !== e || lat != el || bad || !idle) begin
                miscompares++;
                $display("FAIL rand op=%h a=%h b=%h: got %h lat %0d want %h lat %0d",
                         op, a, b, r, lat, e, el);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_mul();
        test_div();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
